// File: rtl/mc_datapath_p.sv
// mc_datapath_p: multicycle ARM-style datapath; define MC_DP_SHIFTER_EN to add a barrel shifter on the B operand
module mc_datapath_p #(
  parameter int unsigned DW = 32,
  parameter logic [DW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic [DW-1:0] Adr,
  output logic [DW-1:0] WriteData,
  input  logic [DW-1:0] ReadData,
  input  logic          MemReady,
  output logic          Stall,
  output logic [31:0]   Instr,
  output logic [3:0]    ALUFlags,
  input  logic          PCWrite,
  input  logic          RegWrite,
  input  logic          IRWrite,
  input  logic          AdrSrc,
  input  logic [1:0]    RegSrc,
  input  logic [1:0]    ALUSrcA,
  input  logic [1:0]    ALUSrcB,
  input  logic [1:0]    ResultSrc,
  input  logic [1:0]    ImmSrc,
  input  logic [2:0]    ALUControl
);
  logic [DW-1:0] pc, data, a, b, alu_out, result, alu_result;
  logic [DW-1:0] src_a, src_b, bb, ext_imm, op2, rd1, rd2;
  logic [DW:0]   sum;
  logic [31:0]   ir;
  logic [DW-1:0] rf [16];
  logic [3:0]    ra1, ra2, wa;
  logic          sh_c, is_sub, arith, logic_op, c, v;

  assign Stall     = ~MemReady;
  assign Instr     = ir;
  assign WriteData = b;
  assign Adr       = AdrSrc ? alu_out : pc;
  assign ra1       = RegSrc[0] ? 4'd15 : ir[19:16];
  assign ra2       = RegSrc[1] ? ir[15:12] : ir[3:0];
  assign wa        = ir[15:12];
  // R15 is never stored; it reads as the current Result
  assign rd1       = &ra1 ? result : rf[ra1];
  assign rd2       = &ra2 ? result : rf[ra2];

  // immediate extension
  assign ext_imm = ImmSrc == 2'd0 ? {{(DW-8){1'b0}}, ir[7:0]} :
                   ImmSrc == 2'd1 ? {{(DW-12){1'b0}}, ir[11:0]} :
                   ImmSrc == 2'd2 ? {{(DW-26){ir[23]}}, ir[23:0], 2'b00} : '0;

`ifdef MC_DP_SHIFTER_EN
  logic [4:0]    sh;
  logic [DW:0]   lsl, lsr;
  logic [DW-1:0] asr, ror;
  // barrel shifter; carry is the last bit shifted out, zero for a zero amount
  always_comb begin
    sh   = ir[11:7];
    lsl  = {1'b0, b} << sh;
    lsr  = {b, 1'b0} >> sh;
    asr  = $signed(b) >>> sh;
    ror  = (b >> sh) | (b << (7'(DW) - 7'(sh)));
    op2  = ir[6:5] == 2'd0 ? lsl[DW-1:0] : ir[6:5] == 2'd1 ? lsr[DW:1] : ir[6:5] == 2'd2 ? asr : ror;
    sh_c = sh == 5'd0 ? 1'b0 : ir[6:5] == 2'd0 ? lsl[DW] : ir[6:5] == 2'd3 ? ror[DW-1] : lsr[0];
  end
`else
  assign op2  = b;
  assign sh_c = 1'b0;
`endif

  assign src_a = ALUSrcA[1] ? alu_out : ALUSrcA[0] ? pc : a;
  assign src_b = ALUSrcB == 2'd0 ? op2 : ALUSrcB == 2'd1 ? ext_imm :
                 ALUSrcB == 2'd2 ? {{(DW-3){1'b0}}, 3'd4} : '0;

  // ALU with NZCV flags; subtraction is add of the complement so C means no-borrow
  always_comb begin
    is_sub     = ALUControl == 3'd1;
    arith      = ALUControl[2:1] == 2'b00;
    logic_op   = ALUControl == 3'd2 || ALUControl == 3'd3 || ALUControl == 3'd4;
    bb         = is_sub ? ~src_b : src_b;
    sum        = {1'b0, src_a} + {1'b0, bb} + {{DW{1'b0}}, is_sub};
    alu_result = arith ? sum[DW-1:0] : ALUControl == 3'd2 ? src_a & src_b :
                 ALUControl == 3'd3 ? src_a | src_b : ALUControl == 3'd4 ? src_a ^ src_b : '0;
    c          = arith ? sum[DW] : logic_op & (ALUSrcB == 2'd0) & sh_c;
    v          = arith & (src_a[DW-1] == bb[DW-1]) & (sum[DW-1] != src_a[DW-1]);
    ALUFlags   = {alu_result[DW-1], alu_result == '0, c, v};
  end

  assign result = ResultSrc[1] ? alu_result : ResultSrc[0] ? data : alu_out;

  // architectural registers; everything holds while memory is not ready
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      data    <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
    end else if (MemReady) begin
      if (PCWrite) pc <= result;
      if (IRWrite) ir <= ReadData[31:0];
      data    <= ReadData;
      a       <= rd1;
      b       <= rd2;
      alu_out <= alu_result;
    end
  end

  // register file write port; not cleared by reset
  always_ff @(posedge clk) begin
    if (!reset && MemReady && RegWrite && wa != 4'hF) rf[wa] <= result;
  end
endmodule

// File: tb/tb_mc_datapath_p.sv
// tb_mc_datapath_p: directed self-checking bench for mc_datapath_p
module tb_mc_datapath_p;
  logic        clk = 0, reset, MemReady, Stall, PCWrite, RegWrite, IRWrite, AdrSrc;
  logic [31:0] Adr, WriteData, ReadData, Instr;
  logic [3:0]  ALUFlags;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;
  int checks = 0, errors = 0;

  mc_datapath_p #(.DW(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData),
    .MemReady(MemReady), .Stall(Stall), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    {reset, PCWrite, RegWrite, IRWrite, AdrSrc} = '0;
    {RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc} = '0;
    ALUControl = 3'd0;
    MemReady = 1'b1;
  endtask

  task automatic load_ir(input logic [31:0] ins);
    ReadData = ins;
    IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0;
  endtask

  task automatic write_reg(input logic [3:0] rd, input logic [31:0] val);
    set_idle();
    load_ir({16'h0, rd, 12'h0});
    ReadData = val;
    tick();
    ResultSrc = 2'b01;
    RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0;
    ResultSrc = 2'b00;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    ReadData = 32'h0;
    tick();
    checks++; if (Adr !== 32'h100) begin errors++; $display("FAIL reset_pc: got %h expected %h", Adr, 32'h100); end
    checks++; if (Instr !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h expected %h", Instr, 32'h0); end
    AdrSrc = 1'b1; #1;
    checks++; if (Adr !== 32'h0) begin errors++; $display("FAIL reset_aluout: got %h expected %h", Adr, 32'h0); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", Stall); end
    set_idle();
  endtask

  task automatic test_fetch();
    set_idle();
    IRWrite = 1'b1; ReadData = 32'hE2811005; ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; PCWrite = 1'b1;
    #1;
    checks++; if (Adr !== 32'h100) begin errors++; $display("FAIL fetch_adr: got %h expected %h", Adr, 32'h100); end
    tick();
    checks++; if (Instr !== 32'hE2811005) begin errors++; $display("FAIL fetch_ir: got %h expected %h", Instr, 32'hE2811005); end
    checks++; if (Adr !== 32'h104) begin errors++; $display("FAIL fetch_pc: got %h expected %h", Adr, 32'h104); end
  endtask

  task automatic test_stall();
    ReadData = 32'hE3A02007;
    MemReady = 1'b0;
    #1;
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL stall_out: got %b expected 1", Stall); end
    repeat (3) tick();
    checks++; if (Adr !== 32'h104) begin errors++; $display("FAIL stall_pc: got %h expected %h", Adr, 32'h104); end
    checks++; if (Instr !== 32'hE2811005) begin errors++; $display("FAIL stall_ir: got %h expected %h", Instr, 32'hE2811005); end
    MemReady = 1'b1;
    #1;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL stall_release: got %b expected 0", Stall); end
    tick();
    checks++; if (Adr !== 32'h108) begin errors++; $display("FAIL stall_resume_pc: got %h expected %h", Adr, 32'h108); end
    checks++; if (Instr !== 32'hE3A02007) begin errors++; $display("FAIL stall_resume_ir: got %h expected %h", Instr, 32'hE3A02007); end
    set_idle();
  endtask

  task automatic test_alu();
    write_reg(4'd1, 32'h7FFFFFFF);
    write_reg(4'd2, 32'h00000001);
    set_idle();
    load_ir(32'h00010002);
    tick();
    checks++; if (ALUFlags !== 4'b1001) begin errors++; $display("FAIL add_ovf_flags: got %b expected %b", ALUFlags, 4'b1001); end
    checks++; if (WriteData !== 32'h1) begin errors++; $display("FAIL writedata_b: got %h expected %h", WriteData, 32'h1); end
    AdrSrc = 1'b1;
    tick();
    checks++; if (Adr !== 32'h80000000) begin errors++; $display("FAIL add_result: got %h expected %h", Adr, 32'h80000000); end
    ALUControl = 3'd1; #1;
    checks++; if (ALUFlags !== 4'b0010) begin errors++; $display("FAIL sub_flags: got %b expected %b", ALUFlags, 4'b0010); end
    tick();
    checks++; if (Adr !== 32'h7FFFFFFE) begin errors++; $display("FAIL sub_result: got %h expected %h", Adr, 32'h7FFFFFFE); end
    ALUControl = 3'd2; #1;
    checks++; if (ALUFlags !== 4'b0000) begin errors++; $display("FAIL and_flags: got %b expected %b", ALUFlags, 4'b0000); end
    tick();
    checks++; if (Adr !== 32'h1) begin errors++; $display("FAIL and_result: got %h expected %h", Adr, 32'h1); end
    ALUControl = 3'd3; tick();
    checks++; if (Adr !== 32'h7FFFFFFF) begin errors++; $display("FAIL or_result: got %h expected %h", Adr, 32'h7FFFFFFF); end
    ALUControl = 3'd4; tick();
    checks++; if (Adr !== 32'h7FFFFFFE) begin errors++; $display("FAIL xor_result: got %h expected %h", Adr, 32'h7FFFFFFE); end
    ALUControl = 3'd5; #1;
    checks++; if (ALUFlags !== 4'b0100) begin errors++; $display("FAIL bad_op_flags: got %b expected %b", ALUFlags, 4'b0100); end
    tick();
    checks++; if (Adr !== 32'h0) begin errors++; $display("FAIL bad_op_result: got %h expected %h", Adr, 32'h0); end
    write_reg(4'd4, 32'd5);
    write_reg(4'd5, 32'd5);
    set_idle();
    load_ir(32'h00040005);
    tick();
    ALUControl = 3'd1; #1;
    checks++; if (ALUFlags !== 4'b0110) begin errors++; $display("FAIL sub_zero_flags: got %b expected %b", ALUFlags, 4'b0110); end
    set_idle();
  endtask

  task automatic test_regfile();
    write_reg(4'd3, 32'hDEADBEEF);
    set_idle();
    load_ir(32'h00030000);
    tick();
    ALUSrcB = 2'b11; AdrSrc = 1'b1;
    tick();
    checks++; if (Adr !== 32'hDEADBEEF) begin errors++; $display("FAIL rf_read: got %h expected %h", Adr, 32'hDEADBEEF); end
    set_idle();
    load_ir(32'h00033000);
    ReadData = 32'h12345678;
    tick();
    ResultSrc = 2'b01; RegWrite = 1'b1; ALUSrcB = 2'b11; AdrSrc = 1'b1;
    tick();
    RegWrite = 1'b0; ResultSrc = 2'b00;
    tick();
    checks++; if (Adr !== 32'hDEADBEEF) begin errors++; $display("FAIL rf_read_old: got %h expected %h", Adr, 32'hDEADBEEF); end
    tick();
    checks++; if (Adr !== 32'h12345678) begin errors++; $display("FAIL rf_read_new: got %h expected %h", Adr, 32'h12345678); end
    write_reg(4'd15, 32'hCAFEF00D);
    set_idle();
    ReadData = 32'h55AA55AA; RegSrc = 2'b01; ResultSrc = 2'b01; ALUSrcB = 2'b11; AdrSrc = 1'b1;
    repeat (3) tick();
    checks++; if (Adr !== 32'h55AA55AA) begin errors++; $display("FAIL r15_reads_result: got %h expected %h", Adr, 32'h55AA55AA); end
    set_idle();
  endtask

  task automatic test_extimm();
    set_idle();
    reset = 1'b1; tick(); reset = 1'b0;
    load_ir(32'h00000ABC);
    ALUSrcA = 2'b01; ALUSrcB = 2'b01; AdrSrc = 1'b1;
    ImmSrc = 2'b00; tick();
    checks++; if (Adr !== 32'h1BC) begin errors++; $display("FAIL imm8: got %h expected %h", Adr, 32'h1BC); end
    ImmSrc = 2'b01; tick();
    checks++; if (Adr !== 32'hBBC) begin errors++; $display("FAIL imm12: got %h expected %h", Adr, 32'hBBC); end
    ImmSrc = 2'b11; tick();
    checks++; if (Adr !== 32'h100) begin errors++; $display("FAIL imm_zero: got %h expected %h", Adr, 32'h100); end
    load_ir(32'h00800001);
    ImmSrc = 2'b10; tick();
    checks++; if (Adr !== 32'hFE000104) begin errors++; $display("FAIL imm_branch: got %h expected %h", Adr, 32'hFE000104); end
    ALUSrcB = 2'b11; tick();
    checks++; if (Adr !== 32'h100) begin errors++; $display("FAIL srcb_zero: got %h expected %h", Adr, 32'h100); end
    ALUSrcA = 2'b10; ALUSrcB = 2'b10; tick(); tick();
    checks++; if (Adr !== 32'h108) begin errors++; $display("FAIL srca_aluout: got %h expected %h", Adr, 32'h108); end
    ResultSrc = 2'b00; PCWrite = 1'b1; tick();
    PCWrite = 1'b0; AdrSrc = 1'b0; #1;
    checks++; if (Adr !== 32'h108) begin errors++; $display("FAIL pc_from_aluout: got %h expected %h", Adr, 32'h108); end
    set_idle();
  endtask

  task automatic test_reset_in_stall();
    set_idle();
    MemReady = 1'b0; reset = 1'b1;
    tick();
    checks++; if (Adr !== 32'h100) begin errors++; $display("FAIL stall_reset_pc: got %h expected %h", Adr, 32'h100); end
    checks++; if (Instr !== 32'h0) begin errors++; $display("FAIL stall_reset_ir: got %h expected %h", Instr, 32'h0); end
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL stall_reset_stall: got %b expected 1", Stall); end
    AdrSrc = 1'b1; #1;
    checks++; if (Adr !== 32'h0) begin errors++; $display("FAIL stall_reset_aluout: got %h expected %h", Adr, 32'h0); end
    set_idle();
  endtask

`ifdef MC_DP_SHIFTER_EN
  task automatic test_shifter();
    write_reg(4'd0, 32'h0);
    write_reg(4'd6, 32'h80000001);
    set_idle();
    load_ir(32'h000000E6);
    tick();
    ALUControl = 3'd3; #1;
    checks++; if (ALUFlags !== 4'b1010) begin errors++; $display("FAIL ror_flags: got %b expected %b", ALUFlags, 4'b1010); end
    AdrSrc = 1'b1; tick();
    checks++; if (Adr !== 32'hC0000000) begin errors++; $display("FAIL ror_result: got %h expected %h", Adr, 32'hC0000000); end
    set_idle();
  endtask
`endif

  initial begin
    set_idle();
    ReadData = 32'h0;
    test_reset();
    test_fetch();
    test_stall();
    test_alu();
    test_regfile();
    test_extimm();
    test_reset_in_stall();
`ifdef MC_DP_SHIFTER_EN
    test_shifter();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_datapath_p.md
MC_DATAPATH_P -- requirements
Module: mc_datapath_p

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning datapath/register/address width (legal 32..64).
REQ-002 The block SHALL have parameter RESET_PC, default 0, meaning PC value loaded on reset.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port Adr  output  DW  memory address.
REQ-006 The block SHALL have port WriteData  output  DW  store data (B register).
REQ-007 The block SHALL have port ReadData  input  DW  memory read data.
REQ-008 The block SHALL have port MemReady  input  1  memory response valid; low stalls the datapath.
REQ-009 The block SHALL have port Stall  output  1  equals ~MemReady.
REQ-010 The block SHALL have port Instr  output  32  instruction register contents.
REQ-011 The block SHALL have port ALUFlags  output  4  {N,Z,C,V} of current ALUResult.
REQ-012 The block SHALL have ports PCWrite, RegWrite, IRWrite, AdrSrc  input  1 each  control enables/select.
REQ-013 The block SHALL have ports RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc  input  2 each, and ALUControl  input  3  control selects.

Function
REQ-014 The block SHALL hold registers PC, IR (32b), Data, A, B, ALUOut and a 16-entry DW-bit register file.
REQ-015 Every register update (PC, IR, Data, A, B, ALUOut, regfile) SHALL occur only when MemReady=1; MemReady=0 holds all state.
REQ-016 PC SHALL load Result when PCWrite=1; IR SHALL load ReadData[31:0] when IRWrite=1; Data, A, B, ALUOut SHALL load every unstalled cycle.
REQ-017 Adr SHALL be PC when AdrSrc=0, ALUOut when AdrSrc=1.
REQ-018 RA1 SHALL be 15 when RegSrc[0]=1 else Instr[19:16]; RA2 SHALL be Instr[15:12] when RegSrc[1]=1 else Instr[3:0].
REQ-019 Reads of register 15 SHALL return Result; RegWrite with Instr[15:12]=15 SHALL not modify the file.
REQ-020 Regfile reads SHALL be combinational; a same-cycle read of the register being written SHALL return the old value.
REQ-021 SrcA SHALL be A (00), PC (01), ALUOut (1x).
REQ-022 SrcB SHALL be B/operand2 (00), ExtImm (01), constant 4 (10), constant 0 (11).
REQ-023 ExtImm SHALL be zero-extended Instr[7:0] (00), zero-extended Instr[11:0] (01), sign-extended {Instr[23:0],2'b00} (10), zero (11).
REQ-024 ALUControl SHALL select add 000, sub 001, and 010, or 011, xor 100; other codes yield ALUResult=0.
REQ-025 N=ALUResult[DW-1], Z=(ALUResult==0); for add/sub C=carry-out (sub: no-borrow) and V=signed overflow, width DW with wrap-around; logical ops C=V=0 unless REQ-031 applies.
REQ-026 Result SHALL be ALUOut (00), Data (01), ALUResult (1x); PCNext SHALL equal Result.

Reset
REQ-027 Reset SHALL set PC=RESET_PC and IR, Data, A, B, ALUOut=0 on the next rising edge, regardless of MemReady.
REQ-028 Reset SHALL not clear the register file; contents are undefined until written.
REQ-029 Reset asserted mid-stall SHALL take effect immediately; Stall still tracks MemReady.

Configuration
REQ-030 Macro MC_DP_SHIFTER_EN SHALL compile in a barrel shifter on the B path for SrcB select 00.
REQ-031 With MC_DP_SHIFTER_EN: operand2 = B shifted by Instr[11:7] per Instr[6:5] (LSL,LSR,ASR,ROR); amount 0 passes B; logical ops set C=last bit shifted out (amount 0: C=0).
REQ-032 Without MC_DP_SHIFTER_EN: operand2 = B unmodified; no shifter logic present.

Verification
REQ-033 reset=1 with RESET_PC=0x100 -> after edge PC=0x100, Adr=0x100, Instr=0, ALUOut=0.
REQ-034 Fetch: AdrSrc=0, IRWrite=1, ReadData=0xE2811005, ALUSrcA=01, ALUSrcB=10, ALUControl=000, ResultSrc=10, PCWrite=1 -> Instr=0xE2811005, PC=0x104.
REQ-035 Same fetch with MemReady=0 for 3 cycles -> Stall=1, PC/Instr unchanged; update occurs on first MemReady=1 edge.
REQ-036 SrcA=0x7FFFFFFF, SrcB=1, add -> ALUResult=0x80000000, flags N=1 Z=0 C=0 V=1; sub 5-5 -> Z=1 C=1.
REQ-037 RegWrite=1, Instr[15:12]=3, Result=0xDEADBEEF -> next cycle RA1=3 reads 0xDEADBEEF; write to R15 ignored.
REQ-038 With MC_DP_SHIFTER_EN: B=0x80000001, Instr[11:7]=1, Instr[6:5]=ROR, or with 0 -> 0xC0000000, C=1.
